cluster_clock_gate_ctrl: RTL and testbench

- Generates the enable for the cluster clock gate (its en_i) from core activity and sleep/wake requests.
- Runs on the free-running, ungated cluster clock, so it keeps operating while the downstream clock is off.
- Applies an idle-hysteresis delay before gating and a settle delay after ungating.
- Gives the core a one-cycle wake acknowledge once the clock is stable again.

---
 rtl/cluster_clock_gate_ctrl.sv | 157 +++++++++++++++
 tb/tb_cluster_clock_gate_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cluster_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_clock_gate_ctrl
//  Purpose  : Produces the enable for the cluster clock gate from core
//             activity and sleep/wake requests. Runs on the free-running
//             cluster clock. Gating happens only after an idle-hysteresis
//             delay. After ungating, the block waits a settle delay and then
//             pulses a one-cycle wake acknowledge.
//  Ports    : clk_i          free-running (ungated) cluster clock
//             rst_i          asynchronous active-high reset
//             sleep_req_i    core requests clock off (level)
//             busy_i         outstanding core/interconnect activity (level)
//             wake_evt_i     pending interrupt/event, forces wake (level)
//             test_en_i      scan/test mode, holds FSM in RUN
//             stats_clr_i    clears the gated-cycle counter
//             clk_en_o       registered enable to the clock gate
//             gated_o        registered, high while GATED
//             wake_ack_o     registered one-cycle pulse on WAKE->RUN
//             gated_cycles_o gated-cycle count (0 when stats not built)
//  Options  : `define CLK_GATE_STATS_EN builds the 32-bit saturating
//             gated-cycle counter. Without it, gated_cycles_o reads 0.
//  Revision : 1.0  initial release
// ============================================================================
module cluster_clock_gate_ctrl #(
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sleep_req_i,
   input  logic        busy_i,
   input  logic        wake_evt_i,
   input  logic        test_en_i,
   input  logic        stats_clr_i,
   output logic        clk_en_o,
   output logic        gated_o,
   output logic        wake_ack_o,
   output logic [31:0] gated_cycles_o
);

   // The idle and wake phases never overlap, so one counter serves both.
   localparam int MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_IDLE_CNT = 2'd1;
   localparam logic [1:0] ST_GATED    = 2'd2;
   localparam logic [1:0] ST_WAKE     = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             clk_en_nxt, gated_nxt, wake_ack_nxt;
   logic             idle_q;

   assign idle_q = sleep_req_i & ~busy_i & ~wake_evt_i;

   // State register. The outputs are also registered here, decoded from the
   // next state so that they change on the same edge as the transition.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_RUN;
         cnt        <= '0;
         clk_en_o   <= 1'b1;
         gated_o    <= 1'b0;
         wake_ack_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         clk_en_o   <= clk_en_nxt;
         gated_o    <= gated_nxt;
         wake_ack_o <= wake_ack_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (test_en_i) begin
         state_nxt = ST_RUN;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (idle_q) begin
                  state_nxt = ST_IDLE_CNT;
                  cnt_nxt   = '0;
               end
            end
            ST_IDLE_CNT: begin
               if (!idle_q) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else if (cnt == IDLE_LAST) begin
                  state_nxt = ST_GATED;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            ST_GATED: begin
               // busy_i alone does not wake; only an event or a dropped request.
               if (wake_evt_i || !sleep_req_i) begin
                  state_nxt = ST_WAKE;
                  cnt_nxt   = '0;
               end
            end
            ST_WAKE: begin
               // Settle phase. Inputs are ignored, so it cannot be aborted.
               if (cnt == WAKE_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Output decode from the next state
   always_comb begin
      clk_en_nxt   = (state_nxt != ST_GATED);
      gated_nxt    = (state_nxt == ST_GATED);
      // A test-mode exit from WAKE is not a wake completion.
      wake_ack_nxt = (state == ST_WAKE) && (state_nxt == ST_RUN) && !test_en_i;
   end

`ifdef CLK_GATE_STATS_EN
   logic [31:0] gated_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gated_cnt <= '0;
      end else if (stats_clr_i) begin
         gated_cnt <= '0;
      end else if ((state == ST_GATED) && (gated_cnt != 32'hFFFF_FFFF)) begin
         gated_cnt <= gated_cnt + 32'd1;
      end
   end

   assign gated_cycles_o = gated_cnt;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr_i;
   assign gated_cycles_o   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cluster_clock_gate_ctrl
//  Purpose  : Directed self-checking bench for cluster_clock_gate_ctrl
//             (IDLE_CYCLES=8, WAKE_CYCLES=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cluster_clock_gate_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sleep_req = 1'b0;
   logic        busy = 1'b0;
   logic        wake_evt = 1'b0;
   logic        test_en = 1'b0;
   logic        stats_clr = 1'b0;
   logic        clk_en, gated, wake_ack;
   logic [31:0] gated_cycles;

   int checks = 0;
   int errors = 0;

   cluster_clock_gate_ctrl #(
      .IDLE_CYCLES(8),
      .WAKE_CYCLES(2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .sleep_req_i   (sleep_req),
      .busy_i        (busy),
      .wake_evt_i    (wake_evt),
      .test_en_i     (test_en),
      .stats_clr_i   (stats_clr),
      .clk_en_o      (clk_en),
      .gated_o       (gated),
      .wake_ack_o    (wake_ack),
      .gated_cycles_o(gated_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One active edge, then settle 1 time unit before sampling or driving.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // ---- reset state
      #12;
      check("rst_clk_en", {31'd0, clk_en}, 32'd1);
      check("rst_gated", {31'd0, gated}, 32'd0);
      check("rst_wake_ack", {31'd0, wake_ack}, 32'd0);
      check("rst_gated_cycles", gated_cycles, 32'd0);
      rst = 1'b0;

      // ---- continuous idle: gating on the 9th edge
      sleep_req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         check($sformatf("idle_en_edge%0d", i), {31'd0, clk_en}, 32'd1);
      end
      step(1);
      check("idle_en_edge9", {31'd0, clk_en}, 32'd0);
      check("idle_gated_edge9", {31'd0, gated}, 32'd1);

      // ---- busy alone does not wake
      busy = 1'b1;
      step(1);
      check("busy_no_wake_en", {31'd0, clk_en}, 32'd0);
      check("busy_no_wake_gated", {31'd0, gated}, 32'd1);
`ifndef CLK_GATE_STATS_EN
      check("stats_tied_zero", gated_cycles, 32'd0);
`endif
      busy = 1'b0;

      // ---- wake event pulse, WAKE_CYCLES=2
      wake_evt  = 1'b1;
      step(1);
      wake_evt  = 1'b0;
      sleep_req = 1'b0;
      check("wake_en_edge1", {31'd0, clk_en}, 32'd1);
      check("wake_gated_edge1", {31'd0, gated}, 32'd0);
      check("wake_ack_edge1", {31'd0, wake_ack}, 32'd0);
      step(1);
      check("wake_ack_edge2", {31'd0, wake_ack}, 32'd0);
      step(1);
      check("wake_ack_edge3", {31'd0, wake_ack}, 32'd1);
      step(1);
      check("wake_ack_edge4", {31'd0, wake_ack}, 32'd0);
      check("wake_run_en", {31'd0, clk_en}, 32'd1);

      // ---- idle 5 edges, busy 1 cycle, idle again: 9 edges after busy drops
      sleep_req = 1'b1;
      step(5);
      busy = 1'b1;
      step(1);
      check("restart_busy_en", {31'd0, clk_en}, 32'd1);
      busy = 1'b0;
      step(8);
      check("restart_en_edge8", {31'd0, clk_en}, 32'd1);
      step(1);
      check("restart_en_edge9", {31'd0, clk_en}, 32'd0);

      // ---- test_en in GATED forces RUN without wake_ack
      test_en = 1'b1;
      step(1);
      check("test_en_clk_en", {31'd0, clk_en}, 32'd1);
      check("test_en_gated", {31'd0, gated}, 32'd0);
      check("test_en_ack", {31'd0, wake_ack}, 32'd0);
      step(1);
      check("test_en_hold_en", {31'd0, clk_en}, 32'd1);
      check("test_en_hold_ack", {31'd0, wake_ack}, 32'd0);
      test_en = 1'b0;
      step(8);
      check("post_test_en_edge8", {31'd0, clk_en}, 32'd1);
      step(1);
      check("post_test_en_edge9", {31'd0, clk_en}, 32'd0);

`ifdef CLK_GATE_STATS_EN
      // ---- gated-cycle statistics (still gated here)
      stats_clr = 1'b1;
      step(1);
      stats_clr = 1'b0;
      check("stats_clr_first", gated_cycles, 32'd0);
      step(100);
      check("stats_100", gated_cycles, 32'd100);
      stats_clr = 1'b1;
      step(1);
      stats_clr = 1'b0;
      check("stats_clr", gated_cycles, 32'd0);
      force dut.gated_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.gated_cnt;
      step(5);
      check("stats_saturate", gated_cycles, 32'hFFFF_FFFF);
`endif

      // ---- asynchronous reset mid-GATED
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_en", {31'd0, clk_en}, 32'd1);
      check("async_rst_gated", {31'd0, gated}, 32'd0);
      check("async_rst_ack", {31'd0, wake_ack}, 32'd0);
      check("async_rst_stats", gated_cycles, 32'd0);
      rst = 1'b0;

      // ---- wake_evt on the threshold edge keeps the clock on
      step(8);
      check("thresh_pre_en", {31'd0, clk_en}, 32'd1);
      wake_evt = 1'b1;
      step(1);
      check("thresh_wake_en", {31'd0, clk_en}, 32'd1);
      check("thresh_wake_gated", {31'd0, gated}, 32'd0);
      wake_evt = 1'b0;
      step(9);
      check("thresh_regate_en", {31'd0, clk_en}, 32'd0);

      // ---- dropping sleep_req wakes from GATED
      sleep_req = 1'b0;
      step(1);
      check("sleep_drop_en", {31'd0, clk_en}, 32'd1);
      step(2);
      check("sleep_drop_ack", {31'd0, wake_ack}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
